id_exe_stage_reg: RTL
=====================

Name: id_exe_stage_reg

Overview:
- Pipeline register between the decode stage and the execute stage of the 5-stage ARM-subset core.
- Captures the two register-file read values (reg1/reg2 → Val_Rn/Val_Rm), decoded control, immediates, destination, source tags and status carry once per cycle.
- Supports freeze (hazard stall) and flush (taken branch).
- The block also carries a valid bit so downstream forwarding and hazard logic can ignore bubbles.

Parameters:
- DATA_W, 32, width of PC and register values.
- REG_AW, 4, register address width (registers 0..14; 15 = PC, never a Dest).

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  taken branch in EXE; insert bubble.
- freeze  in  1  hazard stall; hold contents.
- PC_in  in  DATA_W  decode-stage PC+4.
- Val_Rn_in  in  DATA_W  register-file reg1.
- Val_Rm_in  in  DATA_W  register-file reg2.
- src1_in  in  REG_AW  Rn tag.
- src2_in  in  REG_AW  Rm/Rd tag.
- Dest_in  in  REG_AW  destination register.
- EXE_CMD_in  in  4  ALU command.
- MEM_R_EN_in  in  1  load.
- MEM_W_EN_in  in  1  store.
- WB_EN_in  in  1  writeback enable.
- B_in  in  1  branch.
- S_in  in  1  update status.
- Imm_in  in  1  immediate operand select.
- Shift_operand_in  in  12  shifter operand field.
- Signed_imm_24_in  in  24  branch offset.
- C_in  in  1  status-register carry.
- All of the above without the _in suffix  out  same widths  registered copies.
- valid  out  1  stage holds a real instruction.

Behaviour:
- Priority per posedge: rst (async) > flush > freeze > load.
- Reset:
  - All outputs, including valid, go to 0 immediately on rst rising, without waiting for clk.
  - Outputs stay 0 while rst is high.
  - On the first posedge after rst falls, a normal load occurs.
- Load (flush=0, freeze=0):
  - Every output takes its _in value at the posedge.
  - valid <= 1.
  - Latency is exactly 1 cycle.
- Freeze (flush=0, freeze=1):
  - Every output, including valid, holds its value.
  - Inputs are ignored.
- Flush (flush=1, regardless of freeze):
  - Bubble is inserted.
  - WB_EN, MEM_R_EN, MEM_W_EN, B, S and valid <= 0.
  - EXE_CMD, Dest, src1, src2, Imm, Shift_operand, Signed_imm_24, PC, Val_Rn, Val_Rm and C <= 0.
- A bubble must never cause a writeback, memory access, branch or status update downstream.
- Flush and freeze in the same cycle: flush wins. The next cycle holds the bubble if freeze persists alone.
- Register-file write timing:
  - The register file writes on negedge and reads combinationally, so a same-cycle writeback is already visible at Val_Rn_in/Val_Rm_in at the posedge.
  - This block performs no bypass.
- Dest_in = 15 with WB_EN_in = 1 is illegal from decode.
  - The block passes it through unchanged.
  - The bench flags it as an assertion failure.
- No combinational path from any input to any output; outputs are purely registered.

Test Plan:
1. Reset mid-operation: load PC_in=0x10, WB_EN_in=1, then raise rst between clock edges → all outputs and valid are 0 before the next posedge. First posedge after release loads current inputs with valid=1.
2. Normal load: Val_Rn_in=0x5, Val_Rm_in=0xA, Dest_in=3, EXE_CMD_in=0x2, WB_EN_in=1 → the same values and valid=1 appear after exactly one posedge. Changing inputs mid-cycle has no effect on outputs.
3. Freeze hold: load Dest=7, WB_EN=1. Assert freeze for 3 cycles while driving Dest_in=9 → outputs stay Dest=7, WB_EN=1, valid=1. After release, the next posedge shows Dest=9.
4. Flush bubble: MEM_W_EN_in=1, B_in=1, S_in=1, Val_Rn_in=0xFFFFFFFF with flush=1 → next posedge gives all outputs 0 and valid=0.
5. Flush+freeze together: freeze=1, flush=1 for one cycle, then freeze=1 alone → bubble is inserted and then held (valid=0 for both cycles).
6. Back-to-back: 8 consecutive instructions with Dest 0..7, with no stall or flush → output sequence matches input sequence delayed by one cycle, with no gaps or duplicates.

Source files
------------

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg: decode-to-execute pipeline register with freeze, flush and a valid bit
module id_exe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic [DATA_W-1:0] PC_in,
    input  logic [DATA_W-1:0] Val_Rn_in,
    input  logic [DATA_W-1:0] Val_Rm_in,
    input  logic [REG_AW-1:0] src1_in,
    input  logic [REG_AW-1:0] src2_in,
    input  logic [REG_AW-1:0] Dest_in,
    input  logic [3:0]        EXE_CMD_in,
    input  logic              MEM_R_EN_in,
    input  logic              MEM_W_EN_in,
    input  logic              WB_EN_in,
    input  logic              B_in,
    input  logic              S_in,
    input  logic              Imm_in,
    input  logic [11:0]       Shift_operand_in,
    input  logic [23:0]       Signed_imm_24_in,
    input  logic              C_in,
    output logic [DATA_W-1:0] PC,
    output logic [DATA_W-1:0] Val_Rn,
    output logic [DATA_W-1:0] Val_Rm,
    output logic [REG_AW-1:0] src1,
    output logic [REG_AW-1:0] src2,
    output logic [REG_AW-1:0] Dest,
    output logic [3:0]        EXE_CMD,
    output logic              MEM_R_EN,
    output logic              MEM_W_EN,
    output logic              WB_EN,
    output logic              B,
    output logic              S,
    output logic              Imm,
    output logic [11:0]       Shift_operand,
    output logic [23:0]       Signed_imm_24,
    output logic              C,
    output logic              valid
);
    typedef struct packed {
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] val_rn;
        logic [DATA_W-1:0] val_rm;
        logic [REG_AW-1:0] src1;
        logic [REG_AW-1:0] src2;
        logic [REG_AW-1:0] dest;
        logic [3:0]        exe_cmd;
        logic              mem_r_en;
        logic              mem_w_en;
        logic              wb_en;
        logic              b;
        logic              s;
        logic              imm;
        logic [11:0]       shift_operand;
        logic [23:0]       signed_imm_24;
        logic              c;
        logic              valid;
    } stage_t;

    stage_t stage_d, stage_q, load_s;

    // Next contents: a flush zeroes everything (a clean bubble), a freeze holds, otherwise load decode
    always_comb begin
        load_s = '{pc: PC_in, val_rn: Val_Rn_in, val_rm: Val_Rm_in, src1: src1_in, src2: src2_in,
                   dest: Dest_in, exe_cmd: EXE_CMD_in, mem_r_en: MEM_R_EN_in, mem_w_en: MEM_W_EN_in,
                   wb_en: WB_EN_in, b: B_in, s: S_in, imm: Imm_in, shift_operand: Shift_operand_in,
                   signed_imm_24: Signed_imm_24_in, c: C_in, valid: 1'b1};
        stage_d = flush ? '0 : freeze ? stage_q : load_s;
    end

    // Stage register; reset clears it immediately, independent of the clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    assign PC            = stage_q.pc;
    assign Val_Rn        = stage_q.val_rn;
    assign Val_Rm        = stage_q.val_rm;
    assign src1          = stage_q.src1;
    assign src2          = stage_q.src2;
    assign Dest          = stage_q.dest;
    assign EXE_CMD       = stage_q.exe_cmd;
    assign MEM_R_EN      = stage_q.mem_r_en;
    assign MEM_W_EN      = stage_q.mem_w_en;
    assign WB_EN         = stage_q.wb_en;
    assign B             = stage_q.b;
    assign S             = stage_q.s;
    assign Imm           = stage_q.imm;
    assign Shift_operand = stage_q.shift_operand;
    assign Signed_imm_24 = stage_q.signed_imm_24;
    assign C             = stage_q.c;
    assign valid         = stage_q.valid;
endmodule
